// File: rtl/bshift_pkg.sv
// Shared definitions for the barrel-shift arbiter: default widths, shift-mode
// encodings and the round-robin pointer wrap helper.
package bshift_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_SHAMT_W = 3;
  localparam int PTR_W       = 2;

  localparam logic ROT = 1'b1;
  localparam logic SHL = 1'b0;

  function automatic logic [PTR_W-1:0] next_rr(input logic [PTR_W-1:0] ptr,
                                               input int unsigned n);
    logic [PTR_W-1:0] nxt;
    if ((32'(ptr) + 32'd1) >= n) begin
      nxt = '0;
    end else begin
      nxt = ptr + 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bshift_core.sv
// Combinational shift/rotate-left core built from log2 mux layers, where
// layer k moves the word by 2**k positions when shamt bit k is set.
module bshift_core
  import bshift_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic [DATA_W-1:0]  data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               rot_i,
  output logic [DATA_W-1:0]  result_o
);

  logic [DATA_W-1:0] stage_s [SHAMT_W+1];

  assign stage_s[0] = data_i;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    localparam int AMT     = 1 << k;
    localparam int ROT_AMT = AMT % DATA_W;

    logic [DATA_W-1:0] shl_s;
    logic [DATA_W-1:0] rol_s;

    // A layer that moves by DATA_W or more flushes a logical shift to zero
    if (AMT >= DATA_W) begin : g_shl_flush
      assign shl_s = '0;
    end else begin : g_shl_move
      assign shl_s = stage_s[k] << AMT;
    end

    if (ROT_AMT == 0) begin : g_rol_id
      assign rol_s = stage_s[k];
    end else begin : g_rol_move
      assign rol_s = (stage_s[k] << ROT_AMT) | (stage_s[k] >> (DATA_W - ROT_AMT));
    end

    assign stage_s[k+1] = !shamt_i[k]   ? stage_s[k] :
                          (rot_i == SHL) ? shl_s      : rol_s;
  end

  assign result_o = stage_s[SHAMT_W];

endmodule

// File: rtl/barrel_shift_arbiter.sv
// Round-robin arbiter sharing one barrel-shift core between NUM_REQ
// valid/ready requesters, with a single tagged result register.
module barrel_shift_arbiter
  import bshift_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SHAMT_W = DEF_SHAMT_W,
  parameter int ID_W    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
  input  logic [NUM_REQ*SHAMT_W-1:0] req_shamt_i,
  input  logic [NUM_REQ-1:0]         req_rot_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [DATA_W-1:0]          rsp_data_o,
  output logic [ID_W-1:0]            rsp_id_o,
  output logic [7:0]                 busy_cnt_o
);

  logic [PTR_W-1:0]   rr_ptr_q,    rr_ptr_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q,  rsp_data_d;
  logic [ID_W-1:0]    rsp_id_q,    rsp_id_d;
  logic [7:0]         busy_cnt_q,  busy_cnt_d;

  logic               open_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [ID_W-1:0]    sel_s;
  logic               xfer_s;
  logic [DATA_W-1:0]  op_data_s;
  logic [SHAMT_W-1:0] op_shamt_s;
  logic               op_rot_s;
  logic [DATA_W-1:0]  core_result_s;

  assign open_s = !rsp_valid_q || rsp_ready_i;

  // Grants are held off during reset so nothing is accepted into a register
  // that is being cleared.
  always_comb begin
    grant_s = '0;
    sel_s   = '0;
    if (open_s && !rst) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if ((grant_s == '0) && req_valid_i[i] &&
              (((32'(rr_ptr_q) + 32'(off)) % 32'(NUM_REQ)) == 32'(i))) begin
            grant_s[i] = 1'b1;
            sel_s      = ID_W'(i);
          end else begin
            grant_s = grant_s;
          end
        end
      end
    end else begin
      grant_s = '0;
    end
  end

  assign xfer_s = |(grant_s & req_valid_i);

  always_comb begin
    op_data_s  = '0;
    op_shamt_s = '0;
    op_rot_s   = SHL;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_s == ID_W'(i)) begin
        op_data_s  = req_data_i[i*DATA_W +: DATA_W];
        op_shamt_s = req_shamt_i[i*SHAMT_W +: SHAMT_W];
        op_rot_s   = req_rot_i[i];
      end else begin
        op_rot_s = op_rot_s;
      end
    end
  end

  bshift_core #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_core (
    .data_i   (op_data_s),
    .shamt_i  (op_shamt_s),
    .rot_i    (op_rot_s),
    .result_o (core_result_s)
  );

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    busy_cnt_d  = busy_cnt_q;
    if (xfer_s) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = core_result_s;
      rsp_id_d    = sel_s;
      rr_ptr_d    = next_rr(PTR_W'(sel_s), NUM_REQ);
    end else if (rsp_valid_q && rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
    // Counts stalled cycles only; a cycle with any grant is not a stall
    if ((|req_valid_i) && !xfer_s && (busy_cnt_q != 8'hFF)) begin
      busy_cnt_d = busy_cnt_q + 8'd1;
    end else begin
      busy_cnt_d = busy_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      busy_cnt_q  <= 8'd0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      busy_cnt_q  <= busy_cnt_d;
    end
  end

  assign req_ready_o = grant_s;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_id_o    = rsp_id_q;
  assign busy_cnt_o  = busy_cnt_q;

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Self-checking bench for barrel_shift_arbiter: directed vector table, hand
// sequences for reset/fairness/back-pressure, and a randomized run vs a model.
module tb_barrel_shift_arbiter;

  localparam int N  = 2;
  localparam int W  = 8;
  localparam int S  = 3;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_data;
  logic [N*S-1:0] req_shamt;
  logic [N-1:0]   req_rot;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_data;
  logic [IW-1:0]  rsp_id;
  logic [7:0]     busy_cnt;

  barrel_shift_arbiter #(.NUM_REQ(N), .DATA_W(W), .SHAMT_W(S), .ID_W(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_data_i  (req_data),
    .req_shamt_i (req_shamt),
    .req_rot_i   (req_rot),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_id_o    (rsp_id),
    .busy_cnt_o  (busy_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: the result slot, the priority pointer and the stall count
  int         m_ptr;
  bit         m_valid;
  logic [7:0] m_data;
  int         m_id;
  int         m_busy;
  logic [N-1:0] last_ready;

  typedef struct {
    logic [N-1:0]  valid;
    logic [W-1:0]  data;
    logic [S-1:0]  shamt;
    logic          rot;
    logic [IW-1:0] exp_id;
    logic [W-1:0]  exp_data;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [7:0] ref_shift(input logic [7:0] d, input int sh, input bit rot);
    int v;
    int r;
    v = int'(d);
    if (rot) begin
      r = sh % W;
      v = (v << r) | (v >> (W - r));
    end else if (sh >= W) begin
      v = 0;
    end else begin
      v = v << sh;
    end
    return 8'(v & 255);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_data = 8'h00; m_id = 0; m_busy = 0;
  endtask

  // One clock: check the combinational grant mid-cycle, then advance the
  // model across the edge and check the registered outputs.
  task automatic cycle();
    logic [N-1:0] g;
    int idx;
    #4;
    g = '0;
    idx = -1;
    if (!rst && (!m_valid || rsp_ready)) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (idx < 0 && req_valid[j]) idx = j;
      end
    end
    if (idx >= 0) g[idx] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(g));
    chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
    last_ready = req_ready;
    @(posedge clk);
    #1;
    if (idx >= 0) begin
      m_data  = ref_shift(req_data[idx*W +: W], int'(req_shamt[idx*S +: S]), req_rot[idx]);
      m_id    = idx;
      m_valid = 1;
      m_ptr   = (idx + 1) % N;
    end else if (m_valid && rsp_ready) begin
      m_valid = 0;
    end
    if (req_valid != '0 && idx < 0 && m_busy < 255) m_busy++;
    if (rst) model_reset();
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("rsp_data", 32'(rsp_data), 32'(m_data));
    chk("rsp_id", 32'(rsp_id), 32'(m_id));
    chk("busy_cnt", 32'(busy_cnt), 32'(m_busy));
  endtask

  task automatic set_req(input int i, input logic [W-1:0] d, input logic [S-1:0] s, input logic r);
    req_data[i*W +: W]  = d;
    req_shamt[i*S +: S] = s;
    req_rot[i]          = r;
  endtask

  initial begin
    logic [W-1:0]  held_data;
    logic [IW-1:0] held_id;
    logic [IW-1:0] prev_id;
    int            busy0;

    tbl[0] = '{2'b01, 8'h10, 3'd4, 1'b0, 2'd0, 8'h00};
    tbl[1] = '{2'b01, 8'h10, 3'd4, 1'b1, 2'd0, 8'h01};
    tbl[2] = '{2'b01, 8'h80, 3'd2, 1'b0, 2'd0, 8'h00};
    tbl[3] = '{2'b01, 8'h80, 3'd0, 1'b0, 2'd0, 8'h80};
    tbl[4] = '{2'b01, 8'h81, 3'd7, 1'b1, 2'd0, 8'hC0};
    tbl[5] = '{2'b10, 8'h3C, 3'd3, 1'b1, 2'd1, 8'hE1};
    tbl[6] = '{2'b10, 8'hFF, 3'd7, 1'b0, 2'd1, 8'h80};
    tbl[7] = '{2'b10, 8'hA5, 3'd1, 1'b1, 2'd1, 8'h4B};

    rst = 1'b1; req_valid = '0; req_data = '0; req_shamt = '0; req_rot = '0;
    rsp_ready = 1'b1; last_ready = '0;
    model_reset();
    cycle();
    cycle();
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_busy", 32'(busy_cnt), 32'd0);
    rst = 1'b0;

    // Directed single-request vectors
    for (int v = 0; v < 8; v++) begin
      req_valid = tbl[v].valid;
      set_req(int'(tbl[v].exp_id), tbl[v].data, tbl[v].shamt, tbl[v].rot);
      cycle();
      chk($sformatf("tbl%0d_data", v), 32'(rsp_data), 32'(tbl[v].exp_data));
      chk($sformatf("tbl%0d_id", v), 32'(rsp_id), 32'(tbl[v].exp_id));
      req_valid = '0;
    end
    cycle();

    // Build a stall with a held result, then reset asynchronously mid-cycle
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    set_req(0, 8'h11, 3'd1, 1'b0);
    set_req(1, 8'h22, 3'd2, 1'b1);
    for (int c = 0; c < 3; c++) cycle();
    chk("pre_reset_busy_nonzero", 32'(busy_cnt != 8'd0), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(rsp_valid), 32'd0);
    chk("async_rst_busy", 32'(busy_cnt), 32'd0);
    chk("async_rst_data", 32'(rsp_data), 32'd0);
    chk("async_rst_ready", 32'(req_ready), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    cycle();
    chk("post_reset_tie_id", 32'(rsp_id), 32'd0);

    // Fairness: both requesters continuously valid with a free consumer
    busy0 = int'(busy_cnt);
    prev_id = rsp_id;
    for (int c = 0; c < 8; c++) begin
      set_req(0, 8'(c), 3'(c), 1'b0);
      set_req(1, 8'(8'hF0 + c), 3'(c + 1), 1'b1);
      cycle();
      chk("fair_valid", 32'(rsp_valid), 32'd1);
      chk("fair_alternate", 32'(rsp_id), 32'(prev_id ^ 2'd1));
      prev_id = rsp_id;
    end
    chk("fair_busy_flat", 32'(busy_cnt), 32'(busy0));

    // Back-pressure: consumer stalls for three cycles
    rsp_ready = 1'b0;
    held_data = rsp_data;
    held_id   = rsp_id;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("bp_ready_zero", 32'(last_ready), 32'd0);
      chk("bp_data_stable", 32'(rsp_data), 32'(held_data));
      chk("bp_id_stable", 32'(rsp_id), 32'(held_id));
    end
    rsp_ready = 1'b1;
    cycle();
    chk("bp_release_grant", 32'($countones(last_ready)), 32'd1);
    chk("bp_release_id", 32'(rsp_id), 32'(held_id ^ 2'd1));
    req_valid = '0;
    cycle();

    // Randomized traffic; a requester holds its request until accepted
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && !last_ready[i])) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          set_req(i, 8'($urandom), 3'($urandom), 1'($urandom));
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
